// File: rtl/load_unit.sv
// load_unit: multi-cycle load unit between execute and the data-memory port.
// Takes one load (funct3 + byte address), issues one aligned word read, or two
// when the addressed bytes straddle a word boundary, assembles the bytes and
// sign/zero-extends them to XLEN. Illegal funct3 codes, and boundary-crossing
// loads when MISALIGNED_EN=0, complete with resp_fault=1 and no memory traffic.
//
// Ports
//   clk, reset                      clock, async active-high reset
//   req_valid/req_ready             request handshake
//   req_funct3, req_addr            RISC-V load funct3 and byte address
//   mem_req_valid/mem_req_ready     memory read-request handshake
//   mem_addr                        word-aligned read address
//   mem_rvalid, mem_rdata           read data return (little-endian word)
//   resp_valid/resp_ready           result handshake
//   resp_data, resp_fault           extended result, fault flag
//
// state | meaning
// IDLE  | ready for a request
// REQ1  | first (or only) word read requested
// WAIT1 | waiting for first word
// REQ2  | second word read requested (boundary-crossing load)
// WAIT2 | waiting for second word
// RESP  | result presented until consumer accepts
module load_unit #(
  parameter int XLEN          = 32,
  parameter int ADDR_W        = 32,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_fault
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} state_t;

  // Access size in bytes; 0 marks an illegal code for this XLEN.
  function automatic logic [3:0] size_of(input logic [2:0] f3);
    logic [3:0] s;
    case (f3)
      3'b000, 3'b100: s = 4'd1;
      3'b001, 3'b101: s = 4'd2;
      3'b010:         s = 4'd4;
      3'b110:         s = (XLEN == 64) ? 4'd4 : 4'd0;
      3'b011:         s = (XLEN == 64) ? 4'd8 : 4'd0;
      default:        s = 4'd0;
    endcase
    return s;
  endfunction

  function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [3:0] size);
    return (int'(off) + int'(size)) > NB;
  endfunction

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  // cat = {word1, word0}; for single-word loads word1 is don't-care (zero).
  function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] cat,
                                              input logic [OFF_W-1:0]  off,
                                              input logic [2:0]        f3);
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   r;
    sh = cat >> {off, 3'b000};
    case (f3)
      3'b000:  r = XLEN'($signed(sh[7:0]));
      3'b100:  r = XLEN'(sh[7:0]);
      3'b001:  r = XLEN'($signed(sh[15:0]));
      3'b101:  r = XLEN'(sh[15:0]);
      3'b010:  r = XLEN'($signed(sh[31:0]));
      3'b110:  r = XLEN'(sh[31:0]);
      default: r = sh[XLEN-1:0];
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   word0_q, word0_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic              resp_fault_q, resp_fault_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [OFF_W-1:0]  off_q;

  assign off_q = addr_q[OFF_W-1:0];

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    word0_d      = word0_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct3_d     = req_funct3;
          addr_d       = req_addr;
          resp_data_d  = '0;
          resp_fault_d = 1'b0;
          if (size_of(req_funct3) == 4'd0 ||
              (!MISALIGNED_EN && crosses(req_addr[OFF_W-1:0], size_of(req_funct3)))) begin
            resp_fault_d = 1'b1;
            state_d      = RESP;
          end else begin
            state_d = REQ1;
          end
        end
      end
      REQ1: if (mem_req_ready) state_d = WAIT1;
      WAIT1: begin
        if (mem_rvalid) begin
          word0_d = mem_rdata;
          if (crosses(off_q, size_of(funct3_q))) begin
            state_d = REQ2;
          end else begin
            resp_data_d = extract({{XLEN{1'b0}}, mem_rdata}, off_q, funct3_q);
            state_d     = RESP;
          end
        end
      end
      REQ2: if (mem_req_ready) state_d = WAIT2;
      WAIT2: begin
        if (mem_rvalid) begin
          resp_data_d = extract({mem_rdata, word0_q}, off_q, funct3_q);
          state_d     = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_data_d  = '0;
          resp_fault_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered: derive them from the state being entered.
    req_ready_d     = (state_d == IDLE);
    mem_req_valid_d = (state_d == REQ1) || (state_d == REQ2);
    resp_valid_d    = (state_d == RESP);
    if (state_d == REQ1)      mem_addr_d = align(addr_d);
    else if (state_d == REQ2) mem_addr_d = align(addr_d) + ADDR_W'(NB);  // wraps at top of memory
    else                      mem_addr_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      funct3_q        <= '0;
      addr_q          <= '0;
      word0_q         <= '0;
      resp_data_q     <= '0;
      resp_fault_q    <= 1'b0;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      resp_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      funct3_q        <= funct3_d;
      addr_q          <= addr_d;
      word0_q         <= word0_d;
      resp_data_q     <= resp_data_d;
      resp_fault_q    <= resp_fault_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      resp_valid_q    <= resp_valid_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_fault    = resp_fault_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: three instances share the request/handshake inputs
//   a: XLEN=32, MISALIGNED_EN=1   b: XLEN=32, MISALIGNED_EN=0   c: XLEN=64
// All read one shared byte-addressed memory model; expected results are built
// byte-by-byte from that memory.
module tb_load_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic        mem_req_ready = 1'b1;
  logic        resp_ready = 1'b1;

  logic        req_ready_a, mem_req_valid_a, resp_valid_a, resp_fault_a;
  logic [31:0] mem_addr_a, resp_data_a;
  logic        mem_rvalid_a = 1'b0;
  logic [31:0] mem_rdata_a = '0;
  logic        req_ready_b, mem_req_valid_b, resp_valid_b, resp_fault_b;
  logic [31:0] mem_addr_b, resp_data_b;
  logic        mem_rvalid_b = 1'b0;
  logic [31:0] mem_rdata_b = '0;
  logic        req_ready_c, mem_req_valid_c, resp_valid_c, resp_fault_c;
  logic [31:0] mem_addr_c;
  logic [63:0] resp_data_c;
  logic        mem_rvalid_c = 1'b0;
  logic [63:0] mem_rdata_c = '0;

  load_unit #(.XLEN(32), .ADDR_W(32), .MISALIGNED_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_funct3(req_funct3), .req_addr(req_addr), .mem_req_valid(mem_req_valid_a),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr_a), .mem_rvalid(mem_rvalid_a),
    .mem_rdata(mem_rdata_a), .resp_valid(resp_valid_a), .resp_ready(resp_ready),
    .resp_data(resp_data_a), .resp_fault(resp_fault_a));

  load_unit #(.XLEN(32), .ADDR_W(32), .MISALIGNED_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_funct3(req_funct3), .req_addr(req_addr), .mem_req_valid(mem_req_valid_b),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr_b), .mem_rvalid(mem_rvalid_b),
    .mem_rdata(mem_rdata_b), .resp_valid(resp_valid_b), .resp_ready(resp_ready),
    .resp_data(resp_data_b), .resp_fault(resp_fault_b));

  load_unit #(.XLEN(64), .ADDR_W(32), .MISALIGNED_EN(1'b1)) dut_c (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_c),
    .req_funct3(req_funct3), .req_addr(req_addr), .mem_req_valid(mem_req_valid_c),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr_c), .mem_rvalid(mem_rvalid_c),
    .mem_rdata(mem_rdata_c), .resp_valid(resp_valid_c), .resp_ready(resp_ready),
    .resp_data(resp_data_c), .resp_fault(resp_fault_c));

  int num_cmp = 0;
  int num_bad = 0;
  int cyc = 0;
  int rdelay = 0;
  int xl[3] = '{32, 32, 64};
  bit mi[3] = '{1'b1, 1'b0, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model: 32-bit words, hashed default contents
  logic [31:0] mem [int unsigned];

  function automatic logic [31:0] rd32(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = rd32(a);
    return w[8*a[1:0] +: 8];
  endfunction

  // ---------------- memory responders (drive on negedge)
  bit pa, pb, pc;
  int ca, cb, cc;
  logic [31:0] paa, pab, pac;
  logic [31:0] aq_a[$], aq_b[$], aq_c[$];

  always @(negedge clk) begin
    mem_rvalid_a = 1'b0;
    mem_rvalid_b = 1'b0;
    mem_rvalid_c = 1'b0;
    if (pa) begin
      if (ca == 0) begin mem_rvalid_a = 1'b1; mem_rdata_a = rd32(paa); pa = 0; end
      else ca--;
    end
    if (pb) begin
      if (cb == 0) begin mem_rvalid_b = 1'b1; mem_rdata_b = rd32(pab); pb = 0; end
      else cb--;
    end
    if (pc) begin
      if (cc == 0) begin mem_rvalid_c = 1'b1; mem_rdata_c = {rd32(pac + 32'd4), rd32(pac)}; pc = 0; end
      else cc--;
    end
    if (mem_req_valid_a && mem_req_ready) begin pa = 1; ca = rdelay; paa = mem_addr_a; aq_a.push_back(mem_addr_a); end
    if (mem_req_valid_b && mem_req_ready) begin pb = 1; cb = rdelay; pab = mem_addr_b; aq_b.push_back(mem_addr_b); end
    if (mem_req_valid_c && mem_req_ready) begin pc = 1; cc = rdelay; pac = mem_addr_c; aq_c.push_back(mem_addr_c); end
  end

  // ---------------- response monitors
  typedef struct {
    logic [63:0] d;
    logic        f;
    int          first;
  } resp_t;

  resp_t rq_a[$], rq_b[$], rq_c[$];
  bit seen_a, seen_b, seen_c;
  int first_a, first_b, first_c;

  always @(negedge clk) begin
    resp_t t;
    if (reset) begin seen_a = 0; seen_b = 0; seen_c = 0; end
    if (resp_valid_a && !seen_a) begin seen_a = 1; first_a = cyc; end
    if (resp_valid_b && !seen_b) begin seen_b = 1; first_b = cyc; end
    if (resp_valid_c && !seen_c) begin seen_c = 1; first_c = cyc; end
    if (resp_valid_a && resp_ready) begin
      t.d = {32'd0, resp_data_a}; t.f = resp_fault_a; t.first = first_a; rq_a.push_back(t); seen_a = 0;
    end
    if (resp_valid_b && resp_ready) begin
      t.d = {32'd0, resp_data_b}; t.f = resp_fault_b; t.first = first_b; rq_b.push_back(t); seen_b = 0;
    end
    if (resp_valid_c && resp_ready) begin
      t.d = resp_data_c; t.f = resp_fault_c; t.first = first_c; rq_c.push_back(t); seen_c = 0;
    end
  end

  // ---------------- reference model
  // Gathers the addressed bytes from memory and extends them; latency in
  // cycles after the accept cycle assumes mem_req_ready=1 and rdelay=0.
  task automatic model(input logic [2:0] f3, input logic [31:0] addr, input int xlen,
                       input bit mis, output logic [63:0] d, output bit flt,
                       output int lat, output int nrd,
                       output logic [31:0] a0, output logic [31:0] a1);
    int nb, size, off;
    bit sgn, split;
    nb = xlen / 8;
    size = 0;
    sgn = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd4: size = 1;
      3'd1: begin size = 2; sgn = 1; end
      3'd5: size = 2;
      3'd2: begin size = 4; sgn = (xlen == 64); end
      3'd6: size = (xlen == 64) ? 4 : 0;
      3'd3: size = (xlen == 64) ? 8 : 0;
      default: size = 0;
    endcase
    off = int'(addr % nb);
    a0 = addr - off;
    a1 = a0 + nb;
    split = (off + size) > nb;
    d = '0;
    if (size == 0 || (split && !mis)) begin
      flt = 1; lat = 0; nrd = 0;
    end else begin
      for (int i = 0; i < size; i++) d[8*i +: 8] = byte_at(addr + 32'(i));
      if (sgn && d[8*size-1]) for (int j = 8*size; j < 64; j++) d[j] = 1'b1;
      if (xlen == 32) d[63:32] = '0;
      flt = 0;
      lat = split ? 4 : 2;
      nrd = split ? 2 : 1;
    end
  endtask

  typedef struct {
    bit          got;
    int          nresp;
    logic [63:0] d;
    logic        f;
    int          lat;
    int          nrd;
    logic [31:0] a0;
    logic [31:0] a1;
  } res_t;

  function automatic res_t mk(input resp_t q[$], input logic [31:0] aq[$], input int c0);
    res_t r;
    r.got = (q.size() > 0);
    r.nresp = q.size();
    r.nrd = aq.size();
    r.d = '0; r.f = 1'b0; r.lat = -1; r.a0 = '0; r.a1 = '0;
    if (r.got) begin r.d = q[0].d; r.f = q[0].f; r.lat = q[0].first - c0; end
    if (aq.size() > 0) r.a0 = aq[0];
    if (aq.size() > 1) r.a1 = aq[1];
    return r;
  endfunction

  task automatic clear_q();
    aq_a.delete(); aq_b.delete(); aq_c.delete();
    rq_a.delete(); rq_b.delete(); rq_c.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready_a && req_ready_b && req_ready_c) && n < 50) begin @(negedge clk); n++; end
  endtask

  // Drives one load to all three units and collects their results.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                          output res_t r[3]);
    int n, c0;
    wait_idle();
    clear_q();
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = f3; req_addr = addr;
    @(posedge clk); #1;
    c0 = cyc;
    req_valid = 1'b0;
    n = 0;
    while ((rq_a.size() == 0 || rq_b.size() == 0 || rq_c.size() == 0) && n < 60) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk); #1;
    r[0] = mk(rq_a, aq_a, c0);
    r[1] = mk(rq_b, aq_b, c0);
    r[2] = mk(rq_c, aq_c, c0);
  endtask

  // ---------------- tests
  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    num_cmp++;
    if ({req_ready_a, mem_req_valid_a, resp_valid_a, resp_fault_a} !== 4'b1000) begin
      num_bad++;
      $display("FAIL reset_ctrl got rdy/mreq/rvld/flt=%b want 1000",
               {req_ready_a, mem_req_valid_a, resp_valid_a, resp_fault_a});
    end
    num_cmp++;
    if (mem_addr_a !== 32'd0 || resp_data_a !== 32'd0) begin
      num_bad++;
      $display("FAIL reset_data got addr=%h data=%h want 0/0", mem_addr_a, resp_data_a);
    end
    num_cmp++;
    if (resp_data_c !== 64'd0 || req_ready_c !== 1'b1) begin
      num_bad++;
      $display("FAIL reset_64 got data=%h rdy=%b want 0/1", resp_data_c, req_ready_c);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr, w0, w1, exp_d;
    bit          exp_f;
    int          exp_lat, exp_nrd;
    bit          nm_f, chk64;
    logic [63:0] exp64;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[7];
    res_t r[3];
    logic [31:0] wa;
    tbl[0] = '{3'b000, 32'h1003, 32'h80FF1234, 32'h0, 32'hFFFFFF80, 0, 2, 1, 0, 0, 64'h0};
    tbl[1] = '{3'b100, 32'h1003, 32'h80FF1234, 32'h0, 32'h00000080, 0, 2, 1, 0, 0, 64'h0};
    tbl[2] = '{3'b001, 32'h1003, 32'hAB000000, 32'h000000CD, 32'hFFFFCDAB, 0, 4, 2, 1, 0, 64'h0};
    tbl[3] = '{3'b101, 32'h1003, 32'hAB000000, 32'h000000CD, 32'h0000CDAB, 0, 4, 2, 1, 0, 64'h0};
    tbl[4] = '{3'b010, 32'h1002, 32'h44332211, 32'h88776655, 32'h66554433, 0, 4, 2, 1, 0, 64'h0};
    tbl[5] = '{3'b011, 32'h1000, 32'h44332211, 32'h88776655, 32'h0, 1, 0, 0, 1, 0, 64'h0};
    tbl[6] = '{3'b011, 32'h0008, 32'h44332211, 32'h88776655, 32'h0, 1, 0, 0, 1, 1, 64'h8877665544332211};
    foreach (tbl[i]) begin
      wa = {tbl[i].addr[31:2], 2'b00};
      mem[wa] = tbl[i].w0;
      mem[wa + 32'd4] = tbl[i].w1;
      run_load(tbl[i].f3, tbl[i].addr, r);
      num_cmp++;
      if (r[0].nresp != 1 || r[0].d[31:0] !== tbl[i].exp_d || r[0].f !== tbl[i].exp_f) begin
        num_bad++;
        $display("FAIL dir_data v%0d got n=%0d d=%h f=%b want 1/%h/%b",
                 i, r[0].nresp, r[0].d[31:0], r[0].f, tbl[i].exp_d, tbl[i].exp_f);
      end
      num_cmp++;
      if (r[0].lat != tbl[i].exp_lat || r[0].nrd != tbl[i].exp_nrd) begin
        num_bad++;
        $display("FAIL dir_timing v%0d got lat=%0d reads=%0d want %0d/%0d",
                 i, r[0].lat, r[0].nrd, tbl[i].exp_lat, tbl[i].exp_nrd);
      end
      if (tbl[i].exp_nrd > 0) begin
        num_cmp++;
        if (r[0].a0 !== wa) begin
          num_bad++;
          $display("FAIL dir_addr0 v%0d got %h want %h", i, r[0].a0, wa);
        end
      end
      if (tbl[i].exp_nrd > 1) begin
        num_cmp++;
        if (r[0].a1 !== wa + 32'd4) begin
          num_bad++;
          $display("FAIL dir_addr1 v%0d got %h want %h", i, r[0].a1, wa + 32'd4);
        end
      end
      num_cmp++;
      if (r[1].f !== tbl[i].nm_f || (tbl[i].nm_f && (r[1].d !== 64'd0 || r[1].nrd != 0 || r[1].lat != 0))) begin
        num_bad++;
        $display("FAIL dir_nomis v%0d got f=%b d=%h reads=%0d lat=%0d want f=%b",
                 i, r[1].f, r[1].d, r[1].nrd, r[1].lat, tbl[i].nm_f);
      end
      if (tbl[i].chk64) begin
        num_cmp++;
        if (r[2].d !== tbl[i].exp64 || r[2].f !== 1'b0 || r[2].nrd != 1 || r[2].a0 !== 32'h8) begin
          num_bad++;
          $display("FAIL dir_ld64 got d=%h f=%b reads=%0d a0=%h want %h/0/1/00000008",
                   r[2].d, r[2].f, r[2].nrd, r[2].a0, tbl[i].exp64);
        end
      end
    end
  endtask

  task automatic test_random();
    res_t r[3];
    logic [2:0] f3;
    logic [31:0] addr;
    logic [63:0] ed;
    bit ef;
    int el, en;
    logic [31:0] ea0, ea1;
    for (int it = 0; it < 60; it++) begin
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom();
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFF8 | 32'($urandom_range(0, 7));
      mem[{addr[31:2], 2'b00}] = $urandom();
      run_load(f3, addr, r);
      for (int j = 0; j < 3; j++) begin
        model(f3, addr, xl[j], mi[j], ed, ef, el, en, ea0, ea1);
        num_cmp++;
        if (r[j].nresp != 1 || r[j].d !== ed || r[j].f !== ef) begin
          num_bad++;
          $display("FAIL rnd_data u%0d f3=%0d addr=%h got n=%0d d=%h f=%b want 1/%h/%b",
                   j, f3, addr, r[j].nresp, r[j].d, r[j].f, ed, ef);
        end
        num_cmp++;
        if (r[j].lat != el || r[j].nrd != en) begin
          num_bad++;
          $display("FAIL rnd_timing u%0d f3=%0d addr=%h got lat=%0d reads=%0d want %0d/%0d",
                   j, f3, addr, r[j].lat, r[j].nrd, el, en);
        end
        if (en > 0) begin
          num_cmp++;
          if (r[j].a0 !== ea0 || (en > 1 && r[j].a1 !== ea1)) begin
            num_bad++;
            $display("FAIL rnd_addr u%0d addr=%h got %h,%h want %h,%h",
                     j, addr, r[j].a0, r[j].a1, ea0, ea1);
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    res_t r[3];
    logic [63:0] ed;
    bit ef;
    int el, en;
    logic [31:0] ea0, ea1;
    run_load(3'b010, 32'hFFFFFFFE, r);
    model(3'b010, 32'hFFFFFFFE, 32, 1'b1, ed, ef, el, en, ea0, ea1);
    num_cmp++;
    if (r[0].nrd != 2 || r[0].a0 !== 32'hFFFFFFFC || r[0].a1 !== 32'h00000000) begin
      num_bad++;
      $display("FAIL wrap_addr got reads=%0d %h,%h want 2 fffffffc,00000000", r[0].nrd, r[0].a0, r[0].a1);
    end
    num_cmp++;
    if (r[0].d !== ed || r[0].f !== 1'b0) begin
      num_bad++;
      $display("FAIL wrap_data got %h/%b want %h/0", r[0].d, r[0].f, ed);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] ed;
    bit ef;
    int el, en, n;
    logic [31:0] ea0, ea1;
    wait_idle();
    clear_q();
    mem[32'h2000] = $urandom();
    mem[32'h2004] = $urandom();
    model(3'b010, 32'h2002, 32, 1'b1, ed, ef, el, en, ea0, ea1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0; resp_ready = 1'b0;
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h2002;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      num_cmp++;
      if (mem_req_valid_a !== 1'b1 || mem_addr_a !== 32'h2000) begin
        num_bad++;
        $display("FAIL bp_memreq k%0d got v=%b a=%h want 1/00002000", k, mem_req_valid_a, mem_addr_a);
      end
    end
    @(posedge clk); #1 mem_req_ready = 1'b1;
    n = 0;
    while (!resp_valid_a && n < 30) begin @(negedge clk); n++; end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      num_cmp++;
      if (resp_valid_a !== 1'b1 || {32'd0, resp_data_a} !== ed || resp_fault_a !== 1'b0) begin
        num_bad++;
        $display("FAIL bp_resp k%0d got v=%b d=%h f=%b want 1/%h/0", k, resp_valid_a, resp_data_a, resp_fault_a, ed[31:0]);
      end
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    num_cmp++;
    if (rq_a.size() != 1 || (rq_a.size() > 0 && rq_a[0].d !== ed)) begin
      num_bad++;
      $display("FAIL bp_count got %0d responses want 1 with %h", rq_a.size(), ed[31:0]);
    end
    num_cmp++;
    if (resp_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin
      num_bad++;
      $display("FAIL bp_after got v=%b rdy=%b want 0/1", resp_valid_a, req_ready_a);
    end
  endtask

  task automatic test_reset_mid();
    res_t r[3];
    logic [63:0] ed;
    bit ef;
    int el, en, n, nv, nm;
    logic [31:0] ea0, ea1;
    wait_idle();
    clear_q();
    rdelay = 3;
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = 3'b000; req_addr = 32'h1000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!mem_req_valid_a && n < 10) begin @(negedge clk); n++; end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    num_cmp++;
    if ({req_ready_a, mem_req_valid_a, resp_valid_a, resp_fault_a} !== 4'b1000 ||
        mem_addr_a !== 32'd0 || resp_data_a !== 32'd0) begin
      num_bad++;
      $display("FAIL midrst_out got rdy/mreq/rvld/flt=%b a=%h d=%h want 1000/0/0",
               {req_ready_a, mem_req_valid_a, resp_valid_a, resp_fault_a}, mem_addr_a, resp_data_a);
    end
    @(posedge clk); #1 reset = 1'b0;
    nv = 0; nm = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid_a) nv++;
      if (mem_req_valid_a) nm++;
    end
    num_cmp++;
    if (nv != 0 || nm != 0 || req_ready_a !== 1'b1) begin
      num_bad++;
      $display("FAIL midrst_quiet got resp_cycles=%0d memreq_cycles=%0d rdy=%b want 0/0/1", nv, nm, req_ready_a);
    end
    rdelay = 0;
    run_load(3'b100, 32'h1001, r);
    model(3'b100, 32'h1001, 32, 1'b1, ed, ef, el, en, ea0, ea1);
    num_cmp++;
    if (r[0].nresp != 1 || r[0].d !== ed || r[0].lat != 2) begin
      num_bad++;
      $display("FAIL midrst_recover got n=%0d d=%h lat=%0d want 1/%h/2", r[0].nresp, r[0].d, r[0].lat, ed);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Multi-cycle, parametrised load unit between the execute stage and the data-memory port.
- Accepts one load request (funct3 and byte address). Issues one or two aligned word reads to memory.
- Assembles the addressed bytes across a word boundary when needed, then sign- or zero-extends to XLEN.
- Returns the result with a valid/ready handshake, plus a fault flag for illegal or disallowed accesses.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64; memory word = XLEN/8 bytes.
- ADDR_W, 32, byte-address width.
- MISALIGNED_EN, 1, 1 = split boundary-crossing loads into two reads; 0 = fault them.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request.
- req_funct3  in  3  RISC-V load funct3.
- req_addr  in  ADDR_W  byte address.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  word-aligned read address (low log2(XLEN/8) bits zero).
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read word, little-endian.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  XLEN  extended load result.
- resp_fault  out  1  illegal funct3 or disallowed misaligned access; resp_data = 0 when set.

Behaviour:
- Reset (async): state IDLE. req_ready=1. mem_req_valid=0, mem_addr=0, resp_valid=0, resp_data=0, resp_fault=0. Internal word buffers cleared.
- Reset mid-operation: aborts the access. A memory response arriving later is ignored, because mem_rvalid is only sampled in WAIT states.
- Sizes:
  - 000 LB = 1 byte, signed; 100 LBU = 1 byte, unsigned.
  - 001 LH = 2 bytes, signed; 101 LHU = 2 bytes, unsigned.
  - 010 LW = 4 bytes; signed when XLEN=64, passthrough when XLEN=32.
  - XLEN=64 only: 110 LWU = 4 bytes, unsigned; 011 LD = 8 bytes.
  - All other codes are illegal.
- Address split: off = req_addr mod (XLEN/8). The access is split when off + size > XLEN/8.
- States:
  - IDLE: req_ready=1. On req_valid, latch funct3 and addr.
    - Illegal code, or split with MISALIGNED_EN=0 -> RESP with fault=1.
    - Otherwise -> REQ1.
  - REQ1: mem_req_valid=1, mem_addr = addr with offset bits cleared. On mem_req_ready -> WAIT1.
  - WAIT1: on mem_rvalid, capture word0. Go to REQ2 if split, else to RESP (result computed on this edge).
  - REQ2: mem_req_valid=1, mem_addr = aligned addr + XLEN/8, modulo 2^ADDR_W (top-of-memory wraps to 0). On mem_req_ready -> WAIT2.
  - WAIT2: on mem_rvalid, capture word1, compute result -> RESP.
  - RESP: resp_valid=1 with data/fault held stable. On resp_ready -> IDLE. resp_valid drops the next cycle.
- req_ready=0 in every state except IDLE. No new request is accepted in the RESP handoff cycle.
- Backpressure: while mem_req_ready=0, mem_req_valid and mem_addr stay stable. mem_rvalid outside WAIT1/WAIT2 is ignored.
- Result: concatenate {word1, word0}, shift right by off*8 bits, take the low size*8 bits, then sign- or zero-extend to XLEN.
- Latency with mem_req_ready=1 and rvalid one cycle after the handshake:
  - Aligned: accept edge 0, request cycle 1, rvalid cycle 2, resp_valid cycle 3.
  - Split: resp_valid cycle 5.
  - Fault: resp_valid cycle 1, with no memory request issued.

Test Plan:
- XLEN=32, LB at 0x1003, word@0x1000=0x80FF1234 -> one read at 0x1000; resp_data=0xFFFFFF80, fault=0, resp_valid 3 cycles after accept. Repeat as LBU -> 0x00000080.
- LH at 0x1003, word@0x1000=0xAB000000, word@0x1004=0x000000CD -> reads at 0x1000 then 0x1004; resp_data=0xFFFFCDAB. Repeat as LHU -> 0x0000CDAB.
- LW at 0x1002, words 0x44332211@0x1000 and 0x88776655@0x1004 -> resp_data=0x66554433. With MISALIGNED_EN=0 -> fault=1, data=0, no mem_req_valid.
- funct3=011 with XLEN=32 -> fault=1 one cycle after accept, no memory traffic. With XLEN=64, LD at 0x8 of 0x8877665544332211 -> exact value, single read.
- Hold mem_req_ready low 3 cycles and resp_ready low 2 cycles -> mem_addr, resp_valid and resp_data stable throughout; exactly one response delivered.
- Assert reset while in WAIT1, then pulse mem_rvalid -> state IDLE, all outputs 0, no resp_valid. Split LW at 0xFFFFFFFE -> second read at 0x00000000.
